sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo_param.sv | 107 ++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // Address width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Write/read handshake, status flags and error flags of the FIFO as one bundle.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);

  localparam int LW = $clog2(DEPTH) + 1;

  // A write is taken when wr_en is high and full is low; a read is taken when
  // rd_en is high and empty is low. Read data follows one cycle later,
  // qualified by a single-cycle rd_valid pulse.
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              flush;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, flush, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, flush, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port and one registered read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself carries no reset; only the output register does.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO control: pointers, occupancy, status and sticky error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic               clk,
  input logic               reset,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          rd_valid;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Flush overrides any same-cycle transfer, so it gates both accepts.
  assign wr_acc = bus.wr_en && !full  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Clearing wins over a same-cycle set; a flush cycle leaves the flags alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr_en && full)  overflow  <= 1'b1;
      if (bus.rd_en && empty) underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_acc),
    .waddr  (wr_ptr),
    .wdata  (bus.din),
    .re     (rd_acc),
    .raddr  (rd_ptr),
    .rdata  (bus.dout)
  );

  assign bus.rd_valid     = rd_valid;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= LW'(AF_THRESH));
  assign bus.almost_empty = (level <= LW'(AE_THRESH));
  assign bus.level        = level;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
